// File: rtl/alu_result_fifo.sv
// alu_result_fifo: registered capture FIFO behind the 2-bit ALU result selector.
// Stores result, op and derived zero/msb flags; valid/ready on both sides.
module alu_result_fifo #(
   parameter int WIDTH = 2,
   parameter int SEL_W = 2,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_result,
   input  logic [SEL_W-1:0]           in_op,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_result,
   output logic [SEL_W-1:0]           out_op,
   output logic                       out_zero,
   output logic                       out_msb,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [SEL_W-1:0] op;
      logic             zero;
      logic             msb;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        wdat;
   entry_t        head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   assign full      = (level == LW'(DEPTH));
   assign empty     = (level == '0);
   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign push      = in_valid & ~full;
   assign pop       = ~empty & out_ready;

   always_comb begin
      wdat        = '0;
      wdat.result = in_result;
      wdat.op     = in_op;
      wdat.zero   = ~|in_result;
      wdat.msb    = in_result[WIDTH-1];
   end

   // Storage is never reset; empty-state outputs are masked below.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (in_valid & full) begin
            overflow <= 1'b1;
         end
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      out_result = '0;
      out_op     = '0;
      out_zero   = 1'b1;
      out_msb    = 1'b0;
      if (!empty) begin
         out_result = head.result;
         out_op     = head.op;
         out_zero   = head.zero;
         out_msb    = head.msb;
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed scenario tasks for alu_result_fifo.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_result_fifo;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [1:0] in_result;
   logic [1:0] in_op;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_result;
   logic [1:0] out_op;
   logic       out_zero;
   logic       out_msb;
   logic [2:0] level;
   logic       overflow;

   int tests;
   int fails;

   alu_result_fifo #(.WIDTH(2), .SEL_W(2), .DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_result  (in_result),
      .in_op      (in_op),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_op     (out_op),
      .out_zero   (out_zero),
      .out_msb    (out_msb),
      .level      (level),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_result = 2'd0;
      in_op     = 2'd0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid  = 1'b1;
      in_result = 2'd3;
      in_op     = 2'd1;
      @(negedge clk);
      in_valid = 1'b0;
      tests++;
      if (level !== 3'd1) begin
         fails++;
         $display("FAIL reset_prepush level got %0d want 1", level);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1 ||
          overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_async got v=%b lvl=%0d rdy=%b ovf=%b want 0 0 1 0",
                  out_valid, level, in_ready, overflow);
      end
      tests++;
      if (out_result !== 2'd0 || out_op !== 2'd0 || out_zero !== 1'b1 ||
          out_msb !== 1'b0) begin
         fails++;
         $display("FAIL reset_head got r=%0d op=%0d z=%b m=%b want 0 0 1 0",
                  out_result, out_op, out_zero, out_msb);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_beat;
      in_valid  = 1'b1;
      in_result = 2'b00;
      in_op     = 2'b11;
      out_ready = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_bypass out_valid got %b want 0", out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tests++;
         if (out_valid !== 1'b1 || out_result !== 2'd0 || out_op !== 2'd3 ||
             out_zero !== 1'b1 || out_msb !== 1'b0 || level !== 3'd1) begin
            fails++;
            $display("FAIL single_hold c%0d got v=%b r=%0d op=%0d z=%b m=%b l=%0d want 1 0 3 1 0 1",
                     c, out_valid, out_result, out_op, out_zero, out_msb, level);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      tests++;
      if (level !== 3'd0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_pop got l=%0d v=%b want 0 0", level, out_valid);
      end
   endtask

   task automatic test_fill_order;
      logic [1:0] vals [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      logic       ez   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic       em   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'b1;
         in_result = vals[i];
         in_op     = 2'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      tests++;
      if (level !== 3'd4 || in_ready !== 1'b0 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL fill_full got l=%0d rdy=%b ovf=%b want 4 0 0",
                  level, in_ready, overflow);
      end
      in_valid  = 1'b1;
      in_result = 2'd1;
      in_op     = 2'd2;
      @(negedge clk);
      in_valid = 1'b0;
      tests++;
      if (overflow !== 1'b1 || level !== 3'd4) begin
         fails++;
         $display("FAIL fill_overflow got ovf=%b l=%0d want 1 4", overflow, level);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (out_valid !== 1'b1 || out_result !== vals[i] || out_op !== 2'(i) ||
             out_zero !== ez[i] || out_msb !== em[i]) begin
            fails++;
            $display("FAIL fill_drain%0d got v=%b r=%0d op=%0d z=%b m=%b want 1 %0d %0d %b %b",
                     i, out_valid, out_result, out_op, out_zero, out_msb,
                     vals[i], i, ez[i], em[i]);
         end
         @(negedge clk);
      end
      tests++;
      if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL fill_empty got v=%b l=%0d ovf=%b want 0 0 1",
                  out_valid, level, overflow);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      tests++;
      if (level !== 3'd0) begin
         fails++;
         $display("FAIL empty_pop level got %0d want 0", level);
      end
   endtask

   task automatic test_streaming;
      logic [7:0] wr_cnt;
      logic [7:0] rd_cnt;
      wr_cnt = 8'd0;
      rd_cnt = 8'd0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         in_result = wr_cnt[1:0];
         in_op     = wr_cnt[3:2];
         if (c > 0) begin
            tests++;
            if (out_valid !== 1'b1 || out_result !== rd_cnt[1:0] ||
                out_op !== rd_cnt[3:2] || level !== 3'd1) begin
               fails++;
               $display("FAIL stream_c%0d got v=%b r=%0d op=%0d l=%0d want 1 %0d %0d 1",
                        c, out_valid, out_result, out_op, level,
                        rd_cnt[1:0], rd_cnt[3:2]);
            end
            rd_cnt++;
         end
         wr_cnt++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      tests++;
      if (level !== 3'd1 || out_result !== rd_cnt[1:0] || out_op !== rd_cnt[3:2] ||
          rd_cnt !== 8'd19) begin
         fails++;
         $display("FAIL stream_tail got l=%0d r=%0d op=%0d n=%0d want 1 3 0 19",
                  level, out_result, out_op, rd_cnt);
      end
      @(negedge clk);
      out_ready = 1'b0;
      tests++;
      if (level !== 3'd0) begin
         fails++;
         $display("FAIL stream_drain level got %0d want 0", level);
      end
   endtask

   task automatic test_full_pop;
      logic [1:0] exp [4] = '{2'd2, 2'd1, 2'd0, 2'd2};
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'b1;
         in_result = 2'(3 - i);
         in_op     = 2'd0;
         @(negedge clk);
      end
      in_result = 2'd2;
      in_op     = 2'd1;
      out_ready = 1'b1;
      tests++;
      if (in_ready !== 1'b0 || level !== 3'd4 || out_result !== 2'd3) begin
         fails++;
         $display("FAIL fullpop_pre got rdy=%b l=%0d r=%0d want 0 4 3",
                  in_ready, level, out_result);
      end
      @(negedge clk);
      out_ready = 1'b0;
      tests++;
      if (level !== 3'd3 || out_result !== 2'd2 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL fullpop_blocked got l=%0d r=%0d rdy=%b want 3 2 1",
                  level, out_result, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      tests++;
      if (level !== 3'd4) begin
         fails++;
         $display("FAIL fullpop_refill level got %0d want 4", level);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (out_result !== exp[i] || out_op !== ((i == 3) ? 2'd1 : 2'd0)) begin
            fails++;
            $display("FAIL fullpop_drain%0d got r=%0d op=%0d want %0d %0d",
                     i, out_result, out_op, exp[i], (i == 3) ? 1 : 0);
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 3; i++) begin
         in_valid  = 1'b1;
         in_result = 2'(i + 1);
         in_op     = 2'd0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      tests++;
      if (level !== 3'd3 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL rstmid_pre got l=%0d ovf=%b want 3 1", level, overflow);
      end
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      tests++;
      if (level !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_clear got l=%0d v=%b ovf=%b want 0 0 0",
                  level, out_valid, overflow);
      end
      @(negedge clk);
      in_valid  = 1'b1;
      in_result = 2'd3;
      in_op     = 2'd2;
      @(negedge clk);
      in_valid = 1'b0;
      tests++;
      if (level !== 3'd1 || out_result !== 2'd3 || out_op !== 2'd2 ||
          out_msb !== 1'b1 || out_zero !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_next got l=%0d r=%0d op=%0d m=%b z=%b want 1 3 2 1 0",
                  level, out_result, out_op, out_msb, out_zero);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_single_beat();
      test_fill_order();
      test_streaming();
      test_full_pop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
